// File: rtl/rsa_operand_sram_burst.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// rsa_operand_sram_burst : 1W/1R operand SRAM with valid/ready burst reader.
// Option macro: RSA_SRAM_WR_BYPASS_EN (write-first read/write collisions).
// Revision: 1.0
// ============================================================================
module rsa_operand_sram_burst #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_busy,
  output logic              rd_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_OUT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_last_q, rd_last_d;
  logic                rd_busy_q, rd_busy_d;
  logic                rd_done_q, rd_done_d;
  logic [DATA_W-1:0]   rd_word;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Array has no reset path: writes land in every state, rst included.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef RSA_SRAM_WR_BYPASS_EN
  always_comb begin
    rd_word = mem[addr_q];
    if (wr_en && (wr_addr == addr_q)) begin
      rd_word = wr_data;
    end
  end
`else
  // Same-cycle write to addr_q is not yet visible: old contents are returned.
  always_comb begin
    rd_word = mem[addr_q];
  end
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;
    rd_busy_d   = rd_busy_q;
    rd_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          addr_d      = rd_base;
          remaining_d = rd_len;
          if (rd_len == '0) begin
            state_d   = S_DONE;
            rd_done_d = 1'b1;
          end else begin
            state_d   = S_READ;
            rd_busy_d = 1'b1;
          end
        end
      end
      S_READ: begin
        rd_data_d  = rd_word;
        rd_valid_d = 1'b1;
        rd_last_d  = (remaining_q == (ADDR_W+1)'(1));
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (rd_ready) begin
          rd_valid_d  = 1'b0;
          rd_last_d   = 1'b0;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q > (ADDR_W+1)'(1)) begin
            state_d = S_READ;
          end else begin
            state_d   = S_DONE;
            rd_busy_d = 1'b0;
            rd_done_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        rd_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      rd_busy_q   <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      rd_busy_q   <= rd_busy_d;
      rd_done_q   <= rd_done_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign rd_busy  = rd_busy_q;
  assign rd_done  = rd_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_operand_sram_burst.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_rsa_operand_sram_burst : table-driven bench for the operand burst SRAM.
// Revision: 1.0
// ============================================================================
module tb_rsa_operand_sram_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_start;
  logic [7:0]  rd_base;
  logic [8:0]  rd_len;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_busy;
  logic        rd_done;

  always #5 clk = ~clk;

  rsa_operand_sram_burst #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_start (rd_start),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rd_busy  (rd_busy),
    .rd_done  (rd_done)
  );

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    int          stall_idx;
    int          stall_cyc;
    logic        poke;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] shadow [256];
  vec_t        vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
    shadow[a] = d;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 1;
    while (!rd_valid && cnt < 8) begin
      step();
      cnt++;
    end
  endtask

  task automatic run_burst(input vec_t v);
    int          cnt;
    logic [31:0] held;
    logic        held_last;
    logic [7:0]  a;
    rd_base  = v.base;
    rd_len   = v.len;
    rd_start = 1'b1;
    rd_ready = 1'b1;
    step();
    if (v.poke) begin
      // keep requesting a different burst the whole time; it must be ignored
      rd_base = v.base + 8'd77;
      rd_len  = 9'd5;
    end else begin
      rd_start = 1'b0;
    end
    if (v.len == 9'd0) begin
      chk("zero_len_done", rd_done, 1);
      chk("zero_len_valid", rd_valid, 0);
      chk("zero_len_busy", rd_busy, 0);
      step();
      rd_start = 1'b0;
      chk("zero_len_done_once", rd_done, 0);
      chk("zero_len_valid_later", rd_valid, 0);
      return;
    end
    chk("busy_after_start", rd_busy, 1);
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.base + i[7:0];
      rd_ready = (i == v.stall_idx) ? 1'b0 : 1'b1;
      wait_valid(cnt);
      if (!rd_valid) begin
        chk("valid_timeout", 0, 1);
        rd_start = 1'b0;
        rd_ready = 1'b1;
        return;
      end
      chk("word_gap", cnt, 2);
      chk("data", rd_data, shadow[a]);
      chk("last_flag", rd_last, (i == int'(v.len) - 1));
      chk("busy_in_out", rd_busy, 1);
      if (i == 0) chk("first_word", rd_data, v.exp_first);
      if (i == int'(v.len) - 1) chk("last_word", rd_data, v.exp_last);
      if (i == v.stall_idx) begin
        held      = rd_data;
        held_last = rd_last;
        for (int k = 0; k < v.stall_cyc; k++) begin
          step();
          chk("stall_valid", rd_valid, 1);
          chk("stall_data", rd_data, held);
          chk("stall_last", rd_last, held_last);
        end
        rd_ready = 1'b1;
      end
      step();
      chk("valid_after_hs", rd_valid, 0);
      chk("done_after_hs", rd_done, (i == int'(v.len) - 1));
    end
    chk("busy_in_done", rd_busy, 0);
    step();
    rd_start = 1'b0;
    chk("done_one_cycle", rd_done, 0);
    chk("busy_idle", rd_busy, 0);
    step();
    chk("idle_no_restart_busy", rd_busy, 0);
    chk("idle_no_restart_valid", rd_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [31:0] exp_col;
    vecs[0] = '{8'd0,   9'd64,  -1, 0, 1'b0, 32'd1,   32'd190};
    vecs[1] = '{8'd64,  9'd4,    2, 5, 1'b0, 32'd193, 32'd202};
    vecs[2] = '{8'd254, 9'd4,   -1, 0, 1'b0, 32'd763, 32'd4};
    vecs[3] = '{8'd0,   9'd0,   -1, 0, 1'b0, 32'd0,   32'd0};
    vecs[4] = '{8'd0,   9'd256, -1, 0, 1'b0, 32'd1,   32'd766};
    vecs[5] = '{8'd30,  9'd3,   -1, 0, 1'b1, 32'd91,  32'd97};
    vecs[6] = '{8'd255, 9'd1,    0, 2, 1'b0, 32'd766, 32'd766};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_ready = 1'b1;
    step();
    step();
    chk("reset_valid", rd_valid, 0);
    chk("reset_data", rd_data, 0);
    chk("reset_last", rd_last, 0);
    chk("reset_busy", rd_busy, 0);
    chk("reset_done", rd_done, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 256; i++) begin
      write_word(i[7:0], 32'(i) * 32'd3 + 32'd1);
    end

    for (int n = 0; n < 7; n++) begin
      run_burst(vecs[n]);
    end

    // reset while word 3 of 8 is waiting in OUT; a write issued under rst must stick
    rd_base = 8'd100; rd_len = 9'd8; rd_start = 1'b1; rd_ready = 1'b1;
    step();
    rd_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_valid(cnt);
      chk("rst_pre_data", rd_data, 32'd301 + 32'(i) * 32'd3);
      step();
    end
    rd_ready = 1'b0;
    wait_valid(cnt);
    chk("rst_word3_valid", rd_valid, 1);
    chk("rst_word3_data", rd_data, 32'd307);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 8'd200; wr_data = 32'hDEAD_BEEF;
    step();
    rst = 1'b0; wr_en = 1'b0; shadow[200] = 32'hDEAD_BEEF;
    chk("rst_mid_valid", rd_valid, 0);
    chk("rst_mid_busy", rd_busy, 0);
    chk("rst_mid_done", rd_done, 0);
    chk("rst_mid_data", rd_data, 0);
    rd_ready = 1'b1;
    step();
    chk("rst_no_done", rd_done, 0);
    chk("rst_no_valid", rd_valid, 0);
    run_burst('{8'd198, 9'd4, -1, 0, 1'b0, 32'd595, 32'd604});

    // read/write collision on address 10 during its READ cycle
    write_word(8'd10, 32'hAAAA_AAAA);
    rd_base = 8'd10; rd_len = 9'd1; rd_start = 1'b1; rd_ready = 1'b1;
    step();
    rd_start = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd10; wr_data = 32'h5555_5555;
    step();
    wr_en = 1'b0; shadow[10] = 32'h5555_5555;
`ifdef RSA_SRAM_WR_BYPASS_EN
    exp_col = 32'h5555_5555;
`else
    exp_col = 32'hAAAA_AAAA;
`endif
    chk("collision_valid", rd_valid, 1);
    chk("collision_data", rd_data, exp_col);
    chk("collision_last", rd_last, 1);
    step();
    chk("collision_done", rd_done, 1);
    step();
    run_burst('{8'd10, 9'd1, -1, 0, 1'b0, 32'h5555_5555, 32'h5555_5555});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
